// File: rtl/sound_out_stage.sv
// Mixer output stage: box-car decimation, one-pole DC blocker, ramped mute gain, 16-bit saturation.
// Latency 3 cycles from the final strobe of a group; no backpressure, out_valid is a one-cycle pulse.
module sound_out_stage #(
  parameter int DECIM_LOG2 = 2,
  parameter int DC_SHIFT   = 8,
  parameter int RAMP_STEP  = 1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic signed [15:0] sample_in,
  input  logic               ce_in,
  input  logic               dc_en,
  input  logic               mute,
  output logic signed [15:0] sample_out,
  output logic               out_valid,
  output logic               clip
);

  localparam int AW = 16 + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic [9:0] STEP = 10'(RAMP_STEP);

  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     acc_sum;
  logic [DECIM_LOG2-1:0]    cnt;
  logic signed [15:0]       avg;
  logic                     s1_v;

  logic signed [15:0]       xp;
  logic signed [15:0]       yp;
  logic signed [18:0]       y;
  logic signed [15:0]       ysat;
  logic                     y_clip;
  logic signed [15:0]       dcout;
  logic                     clipf;
  logic                     s2_v;

  logic [8:0]               gain;
  logic [9:0]               gain_ext;
  logic [9:0]               gain_up;
  logic [9:0]               gain_nxt;
  logic signed [25:0]       prod;

  assign acc_sum = acc + {{DECIM_LOG2{sample_in[15]}}, sample_in};

  // 19 bits hold the worst case of avg - xp + yp - (yp >>> DC_SHIFT) without wrap
  assign y = 19'(avg) - 19'(xp) + 19'(yp) - 19'(yp >>> DC_SHIFT);

  always_comb begin
    ysat   = y[15:0];
    y_clip = 1'b0;
    if (y > 19'sd32767) begin
      ysat   = 16'sh7fff;
      y_clip = 1'b1;
    end else if (y < -19'sd32768) begin
      ysat   = 16'sh8000;
      y_clip = 1'b1;
    end
  end

  // gain is 0..256, so the product shifted down by 8 always fits in 16 bits
  assign prod     = 26'(dcout) * 26'($signed({1'b0, gain}));
  assign gain_ext = {1'b0, gain};
  assign gain_up  = gain_ext + STEP;

  always_comb begin
    gain_nxt = gain_ext;
    if (mute) begin
      gain_nxt = (gain_ext < STEP) ? 10'd0 : gain_ext - STEP;
    end else begin
      gain_nxt = (gain_up > 10'd256) ? 10'd256 : gain_up;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      cnt        <= '0;
      avg        <= '0;
      s1_v       <= 1'b0;
      xp         <= '0;
      yp         <= '0;
      dcout      <= '0;
      clipf      <= 1'b0;
      s2_v       <= 1'b0;
      gain       <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      clip       <= 1'b0;
    end else begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;

      if (ce_in) begin
        if (cnt == CNT_LAST) begin
          avg  <= 16'(acc_sum >>> DECIM_LOG2);
          acc  <= '0;
          cnt  <= '0;
          s1_v <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + DECIM_LOG2'(1);
        end
      end

      // filter state tracks the stream even in passthrough so enabling it is glitch-free
      if (s1_v) begin
        xp    <= avg;
        yp    <= ysat;
        dcout <= dc_en ? ysat : avg;
        clipf <= dc_en & y_clip;
        s2_v  <= 1'b1;
      end

      if (s2_v) begin
        sample_out <= 16'(prod >>> 8);
        clip       <= clipf;
        out_valid  <= 1'b1;
        gain       <= 9'(gain_nxt);
      end
    end
  end

endmodule

// File: tb/tb_sound_out_stage.sv
// Directed bench for sound_out_stage: three instances differing only in RAMP_STEP share one stimulus.
`timescale 1ns/100ps
module tb_sound_out_stage;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic signed [15:0] sample_in;
  logic               ce_in;
  logic               dc_en;
  logic               mute;
  logic signed [15:0] so  [3];
  logic               ov  [3];
  logic               clp [3];

  int checks   = 0;
  int failures = 0;
  int last_lat = 0;

  always #12.5 clk_sys = ~clk_sys;

  // index 0: RAMP_STEP 256, index 1: RAMP_STEP 1, index 2: RAMP_STEP 64
  sound_out_stage #(.DECIM_LOG2(2), .DC_SHIFT(8), .RAMP_STEP(256)) u_step256 (
    .clk_sys(clk_sys), .reset_n(reset_n), .sample_in(sample_in), .ce_in(ce_in),
    .dc_en(dc_en), .mute(mute), .sample_out(so[0]), .out_valid(ov[0]), .clip(clp[0]));

  sound_out_stage #(.DECIM_LOG2(2), .DC_SHIFT(8), .RAMP_STEP(1)) u_step1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .sample_in(sample_in), .ce_in(ce_in),
    .dc_en(dc_en), .mute(mute), .sample_out(so[1]), .out_valid(ov[1]), .clip(clp[1]));

  sound_out_stage #(.DECIM_LOG2(2), .DC_SHIFT(8), .RAMP_STEP(64)) u_step64 (
    .clk_sys(clk_sys), .reset_n(reset_n), .sample_in(sample_in), .ce_in(ce_in),
    .dc_en(dc_en), .mute(mute), .sample_out(so[2]), .out_valid(ov[2]), .clip(clp[2]));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ce_in   = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic strobe(input logic signed [15:0] s);
    @(negedge clk_sys);
    sample_in = s;
    ce_in     = 1'b1;
  endtask

  // Four back-to-back strobes; returns one negedge after the last one with ce_in low
  task automatic group4(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c, input logic signed [15:0] d);
    strobe(a);
    strobe(b);
    strobe(c);
    strobe(d);
    @(negedge clk_sys);
    ce_in = 1'b0;
  endtask

  // lat counts negedges since the negedge that drove the final strobe
  task automatic get_out(input int idx, input string tag,
                         input logic signed [15:0] exp_v, input logic exp_c);
    logic               got;
    logic signed [15:0] v;
    logic               c;
    int                 lat;
    got = 1'b0;
    v   = 'x;
    c   = 1'bx;
    lat = 0;
    for (int i = 2; i <= 10 && !got; i++) begin
      @(negedge clk_sys);
      if (ov[idx]) begin
        got = 1'b1;
        v   = so[idx];
        c   = clp[idx];
        lat = i;
      end
    end
    chk({tag, "_vld"}, got, 1);
    chk({tag, "_val"}, v, exp_v);
    chk({tag, "_clip"}, c, exp_c);
    last_lat = lat;
  endtask

  task automatic count_valids(input int idx, input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (ov[idx]) seen++;
    end
  endtask

  int mexp [12] = '{0, 1024, 2048, 3072, 4096, 3072, 2048, 1024, 0, 0, 0, 1024};

  initial begin
    int seen;
    int fexp;
    reset_n   = 1'b0;
    sample_in = '0;
    ce_in     = 1'b0;
    dc_en     = 1'b0;
    mute      = 1'b0;

    #5;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_out%0d", i), so[i], 0);
      chk($sformatf("reset_vld%0d", i), ov[i], 0);
      chk($sformatf("reset_clip%0d", i), clp[i], 0);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Decimation with unity gain after one dummy group
    group4(0, 0, 0, 0);
    get_out(0, "dec_dummy", 0, 0);
    group4(1, 2, 3, 6);
    get_out(0, "dec_pos", 3, 0);
    chk("dec_latency", last_lat, 3);
    @(negedge clk_sys);
    chk("dec_pulse", ov[0], 0);
    group4(-1, -1, -1, -2);
    get_out(0, "dec_neg_floor", -2, 0);

    // Fade-in after reset, RAMP_STEP 1
    do_reset();
    for (int k = 0; k < 258; k++) begin
      group4(1000, 1000, 1000, 1000);
      fexp = (1000 * ((k < 256) ? k : 256)) >>> 8;
      get_out(1, $sformatf("fade%0d", k), 16'(fexp), 0);
    end

    // DC blocker step response
    do_reset();
    dc_en = 1'b1;
    group4(0, 0, 0, 0);
    get_out(0, "dc_prime", 0, 0);
    group4(0, 0, 0, 0);
    get_out(0, "dc_zero", 0, 0);
    group4(10000, 10000, 10000, 10000);
    get_out(0, "dc_step", 10000, 0);
    group4(10000, 10000, 10000, 10000);
    get_out(0, "dc_decay1", 9961, 0);
    group4(10000, 10000, 10000, 10000);
    get_out(0, "dc_decay2", 9923, 0);

    // Saturation
    do_reset();
    dc_en = 1'b1;
    group4(0, 0, 0, 0);
    get_out(0, "sat_prime", 0, 0);
    group4(-32768, -32768, -32768, -32768);
    get_out(0, "sat_min", -32768, 0);
    group4(32767, 32767, 32767, 32767);
    get_out(0, "sat_max_clip", 32767, 1);
    dc_en = 1'b0;
    group4(32767, 32767, 32767, 32767);
    get_out(0, "sat_bypass_noclip", 32767, 0);

    // Mute ramp, RAMP_STEP 64
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 4)  mute = 1'b1;
      if (i == 10) mute = 1'b0;
      group4(4096, 4096, 4096, 4096);
      get_out(2, $sformatf("mute%0d", i), 16'(mexp[i]), 0);
    end

    // Async reset partway through a group
    chk("arst_pre", so[0], 4096);
    strobe(4096);
    strobe(4096);
    @(negedge clk_sys);
    ce_in = 1'b0;
    #5;
    reset_n = 1'b0;
    #1;
    chk("arst_out", so[0], 0);
    chk("arst_vld", ov[0], 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    strobe(100);
    strobe(100);
    strobe(100);
    @(negedge clk_sys);
    ce_in = 1'b0;
    count_valids(0, 6, seen);
    chk("arst_three_strobes", seen, 0);
    strobe(100);
    @(negedge clk_sys);
    ce_in = 1'b0;
    get_out(0, "arst_fourth", 0, 0);

    // Reset with a valid in flight drops it
    group4(4096, 4096, 4096, 4096);
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    count_valids(0, 6, seen);
    chk("arst_pending_drop", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_out_stage.md
Name: sound_out_stage

Overview:
- Output stage directly downstream of the sound mixer; consumes the mixer's 16-bit signed mixed sample at the clk_sys rate.
- Decimates the stream by box-car averaging over 2^DECIM_LOG2 strobes.
- Removes DC with a one-pole high-pass filter, then applies a ramped mute/unmute gain.
- Delivers one saturated 16-bit sample per output strobe to the platform audio path.

Parameters:
- DECIM_LOG2, 2: log2 of the number of ce_in strobes averaged into one output sample (1..10).
- DC_SHIFT, 8: DC-blocker feedback shift; pole = 1 - 2^-DC_SHIFT.
- RAMP_STEP, 1: gain change per output sample while ramping (1..256).

Ports:
- clk_sys  in  1  system clock (40 MHz).
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately.
- sample_in  in  16  signed mixed sample; sampled only when ce_in=1.
- ce_in  in  1  accumulate strobe, one cycle wide.
- dc_en  in  1  1 = DC blocker active; 0 = passthrough (filter state still updates).
- mute  in  1  1 = ramp gain toward 0; 0 = ramp gain toward 256.
- sample_out  out  16  signed output sample; holds between updates.
- out_valid  out  1  one-cycle pulse when sample_out updates.
- clip  out  1  valid with out_valid; 1 if DC stage saturated for this sample.

Behaviour:
- Reset values: sample_out=0, out_valid=0, clip=0. Internally acc=0, cnt=0, xp=0, yp=0, gain=0. Output therefore fades in after reset.
- Stage 0, accumulate:
  - acc is signed, 16+DECIM_LOG2 bits; cnt is DECIM_LOG2 bits.
  - On ce_in with cnt != 2^D-1: acc += sext(sample_in); cnt++.
  - On ce_in with cnt == 2^D-1: avg <= (acc + sext(sample_in)) >>> D (arithmetic, floor); acc <= 0; cnt <= 0; s1_v <= 1 for one cycle.
  - No ce_in: no state change.
- Stage 1, DC blocker (on s1_v):
  - Full-precision result, 19-bit signed: y = avg - xp + yp - (yp >>> DC_SHIFT).
  - ysat = clamp(y, -32768, 32767); clipf = (y != ysat).
  - xp <= avg; yp <= ysat.
  - dcout <= dc_en ? ysat : avg. clipf is forced to 0 when dc_en=0.
  - s2_v <= 1.
- Stage 2, gain (on s2_v):
  - sample_out <= (dcout * gain) >>> 8, using gain before this cycle's update; the result always fits in 16 bits.
  - clip <= clipf; out_valid <= 1.
  - Gain update: if mute, gain <= max(gain - RAMP_STEP, 0); else gain <= min(gain + RAMP_STEP, 256). Gain is 9 bits.
- Latency: the final ce_in of a group at cycle T gives out_valid at T+3 (avg at T+1, dcout at T+2, sample_out at T+3).
- Pipeline stages only advance on their valid pulses; out_valid is low on every other cycle.
- A ce_in arriving while stages 1/2 are busy is accepted normally; the minimum group period is 2^D cycles, so D >= 1 cannot overrun. D=0 is disallowed.
- A mute toggle mid-ramp reverses direction from the current gain on the next sample. There are no jumps.
- reset_n low at any point (mid-accumulation or mid-pipeline): all registers clear asynchronously and pending valids are dropped. After release, a full group of 2^D strobes is required before the next out_valid.
- Arithmetic: all signed, sign-extended; shifts are arithmetic (floor toward -inf).

Test Plan:
- Decimation: D=2, dc_en=0, gain forced to 256 (mute=0, RAMP_STEP=256, one dummy group first); ce_in samples 1,2,3,6 -> sample_out=3, out_valid exactly 3 cycles after the 4th ce_in. Samples -1,-1,-1,-2 -> sample_out=-2.
- Fade-in after reset: RAMP_STEP=1, dc_en=0, constant 1000:
  - first output = 0, second = 3 (1000*1>>>8), third = 7.
  - after 256 groups gain = 256 and output = 1000, holding there.
- DC blocker: dc_en=1, gain=256, after reset input avg 0 -> 0. Next avg steps to 10000 -> 10000, then 9961 (10000 - 39), decaying monotonically toward 0.
- Saturation: dc_en=1, gain=256, fresh reset state:
  - avg -32768 -> output -32768, clip=0.
  - next avg 32767 -> y=32895 -> output 32767, clip=1.
- Mute ramp: gain=256, RAMP_STEP=64, input 4096, assert mute -> outputs 4096, 3072, 2048, 1024, 0, 0. Deassert mute -> 0, 1024, ...
- Async reset: pull reset_n low after 2 of 4 ce_in -> sample_out=0 and out_valid=0 in the same cycle. After release, 3 strobes give no output; the 4th gives out_valid.
